// File: rtl/gshare_pattern_history_table.sv
// Direct-mapped table of saturating direction counters, optionally gshare-indexed,
// with a committed global history register and a saturating mispredict counter.

module gshare_pht_ctr #(
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             inc,
  output logic [CTR_W-1:0] ctr
);
  // Weakly-not-taken; for a 1-bit counter this evaluates to 0.
  localparam logic [CTR_W-1:0] RST_VAL = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] MAX_VAL = '1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctr <= RST_VAL;
    end else if (we) begin
      if (inc && ctr != MAX_VAL)       ctr <= ctr + 1'b1;
      else if (!inc && ctr != '0)      ctr <= ctr - 1'b1;
    end
  end
endmodule

module gshare_pattern_history_table #(
  parameter int INDEX_W = 4,
  parameter int CTR_W   = 2,
  parameter int GHR_W   = 4,
  parameter int GSHARE  = 1,
  parameter int STAT_W  = 32,
  localparam int GHR_PW = (GHR_W > 0) ? GHR_W : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pred_pc,
  output logic               pred_taken,
  output logic [INDEX_W-1:0] pred_index,
  input  logic               upd_valid,
  input  logic [INDEX_W-1:0] upd_index,
  input  logic               upd_taken,
  input  logic               upd_pred,
  input  logic               mem_stall,
  output logic [GHR_PW-1:0]  ghr,
  output logic [STAT_W-1:0]  mispredict_count
);
  localparam int  DEPTH    = 2 ** INDEX_W;
  localparam bit  USE_HIST = (GSHARE != 0) && (GHR_W > 0);

  typedef struct packed {
    logic               fire;
    logic [INDEX_W-1:0] idx;
    logic               taken;
    logic               mis;
  } upd_req_t;

  upd_req_t                      req;
  logic [DEPTH-1:0][CTR_W-1:0]   tbl;
  logic [INDEX_W-1:0]            raw_index;
  logic [INDEX_W-1:0]            hist_ext;
  logic                          unused_pc;

  assign req.fire  = upd_valid & ~mem_stall;
  assign req.idx   = upd_index;
  assign req.taken = upd_taken;
  assign req.mis   = upd_pred ^ upd_taken;

  assign raw_index  = pred_pc[INDEX_W+1:2];
  assign unused_pc  = ^{pred_pc[31:INDEX_W+2], pred_pc[1:0]};
  assign pred_index = USE_HIST ? (raw_index ^ hist_ext) : raw_index;
  // Read straight from the registered table: a same-cycle update is not bypassed.
  assign pred_taken = tbl[pred_index][CTR_W-1];

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    gshare_pht_ctr #(.CTR_W(CTR_W)) u_ctr (
      .clk (clk),
      .rst (rst),
      .we  (req.fire && (req.idx == INDEX_W'(e))),
      .inc (req.taken),
      .ctr (tbl[e])
    );
  end

  if (GHR_W == 0) begin : g_no_ghr
    assign ghr      = 1'b0;
    assign hist_ext = '0;
  end else begin : g_ghr
    logic [GHR_W-1:0] ghr_q;
    if (GHR_W == 1) begin : g_one
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)          ghr_q <= '0;
        else if (req.fire) ghr_q <= req.taken;
      end
    end else begin : g_multi
      // Newest outcome enters at the LSB; the oldest falls off the top.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)          ghr_q <= '0;
        else if (req.fire) ghr_q <= {ghr_q[GHR_W-2:0], req.taken};
      end
    end
    assign ghr      = ghr_q;
    assign hist_ext = INDEX_W'(ghr_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      mispredict_count <= '0;
    else if (req.fire && req.mis && !(&mispredict_count))
      mispredict_count <= mispredict_count + 1'b1;
  end
endmodule

// File: tb/tb_gshare_pattern_history_table.sv
// Two instances (gshare/32-bit stats and pc-only/2-bit stats) share stimulus;
// a reference model predicts outputs, a negedge monitor checks them.

module tb_gshare_pattern_history_table;
  logic        clk = 0;
  logic        rst;
  logic [31:0] pred_pc;
  logic        upd_valid, upd_taken, upd_pred, mem_stall;
  logic [3:0]  upd_index;
  logic        pt_a, pt_b;
  logic [3:0]  pi_a, pi_b, ghr_a, ghr_b;
  logic [31:0] cnt_a;
  logic [1:0]  cnt_b;

  always #5 clk = ~clk;

  gshare_pattern_history_table #(.INDEX_W(4), .CTR_W(2), .GHR_W(4), .GSHARE(1), .STAT_W(32)) dut_a (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pt_a), .pred_index(pi_a),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .mem_stall(mem_stall), .ghr(ghr_a), .mispredict_count(cnt_a));

  gshare_pattern_history_table #(.INDEX_W(4), .CTR_W(2), .GHR_W(4), .GSHARE(0), .STAT_W(2)) dut_b (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pt_b), .pred_index(pi_b),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .mem_stall(mem_stall), .ghr(ghr_b), .mispredict_count(cnt_b));

  // Reference model: counter values as plain integers 0..3.
  int     m_tbl[16];
  int     m_ghr;
  longint m_ca;
  int     m_cb;

  typedef struct {
    bit     pa; int ia; bit pb; int ib; int g; longint ca; int cb;
  } exp_t;
  exp_t exp_q[$];

  int n_vec = 0;
  int n_bad = 0;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_tbl[i] = 1;
    m_ghr = 0; m_ca = 0; m_cb = 0;
  endfunction

  function automatic void model_update(int idx, bit tk, bit pr);
    if (tk) m_tbl[idx] = (m_tbl[idx] < 3) ? m_tbl[idx] + 1 : 3;
    else    m_tbl[idx] = (m_tbl[idx] > 0) ? m_tbl[idx] - 1 : 0;
    m_ghr = ((m_ghr * 2) + tk) % 16;
    if (pr != tk) begin
      if (m_ca < 64'hFFFF_FFFF) m_ca++;
      if (m_cb < 3) m_cb++;
    end
  endfunction

  function automatic exp_t model_outputs(logic [31:0] pc);
    exp_t e;
    int raw;
    raw  = (pc / 4) % 16;
    e.ia = raw ^ m_ghr;
    e.ib = raw;
    e.pa = m_tbl[e.ia] >= 2;
    e.pb = m_tbl[e.ib] >= 2;
    e.g  = m_ghr;
    e.ca = m_ca;
    e.cb = m_cb;
    return e;
  endfunction

  // One cycle of stimulus: inputs change 1 time unit after the rising edge.
  task automatic step(input logic [31:0] pc, input bit v, input int idx, input bit tk,
                      input bit pr, input bit st, input bit r);
    @(posedge clk);
    #1;
    rst = r; pred_pc = pc; upd_valid = v; upd_index = 4'(idx);
    upd_taken = tk; upd_pred = pr; mem_stall = st;
    if (!r) model_reset();
    exp_q.push_back(model_outputs(pc));
    if (r && v && !st) model_update(idx, tk, pr);
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pred_taken_a",  longint'(pt_a),  longint'(e.pa));
      chk("pred_index_a",  longint'(pi_a),  longint'(e.ia));
      chk("pred_taken_b",  longint'(pt_b),  longint'(e.pb));
      chk("pred_index_b",  longint'(pi_b),  longint'(e.ib));
      chk("ghr_a",         longint'(ghr_a), longint'(e.g));
      chk("ghr_b",         longint'(ghr_b), longint'(e.g));
      chk("mispred_a",     longint'(cnt_a), e.ca);
      chk("mispred_b",     longint'(cnt_b), longint'(e.cb));
    end
  end

  initial begin
    rst = 0; pred_pc = 0; upd_valid = 0; upd_index = 0;
    upd_taken = 0; upd_pred = 0; mem_stall = 0;
    model_reset();
    step(0, 1, 3, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    // Reset sweep over all indices.
    for (int i = 0; i < 16; i++) step(32'(i * 4), 0, 0, 0, 0, 0, 1);
    // Saturate up index 5, all mispredicted; then watch PC 0x14.
    for (int i = 0; i < 4; i++) step(32'h14, 1, 5, 1, 0, 0, 1);
    step(32'h14, 0, 0, 0, 0, 0, 1);
    // Saturate down from ST.
    for (int i = 0; i < 4; i++) step(32'h14, 1, 5, 0, 0, 0, 1);
    step(32'h14, 0, 0, 0, 0, 0, 1);
    // Stall holds everything; the same request applies once afterwards.
    for (int i = 0; i < 3; i++) step(32'h14, 1, 5, 1, 0, 1, 1);
    step(32'h14, 1, 5, 1, 0, 0, 1);
    step(32'h14, 0, 5, 1, 0, 0, 1);
    // Build ghr = 1010, then train index 9 and probe PC 0xC.
    step(32'hC, 1, 0, 1, 1, 0, 1);
    step(32'hC, 1, 0, 0, 0, 0, 1);
    step(32'hC, 1, 0, 1, 1, 0, 1);
    step(32'hC, 1, 0, 0, 0, 0, 1);
    step(32'hC, 1, 9, 1, 1, 0, 1);
    step(32'hC, 1, 9, 1, 1, 0, 1);
    step(32'hC, 0, 0, 0, 0, 0, 1);
    // Async reset mid-run with an update presented while reset is low.
    step(32'h24, 1, 9, 1, 0, 0, 0);
    step(32'h24, 1, 9, 1, 0, 0, 0);
    step(32'h24, 0, 0, 0, 0, 0, 1);
    // Mispredict saturation on the 2-bit stat counter.
    for (int i = 0; i < 5; i++) step(32'h8, 1, 2, 1, 0, 0, 1);
    step(32'h8, 0, 0, 0, 0, 0, 1);
    // Random traffic with occasional stalls and reset pulses.
    for (int i = 0; i < 400; i++)
      step($urandom, ($urandom_range(0, 3) != 0), $urandom_range(0, 15), 1'($urandom),
           1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) != 0));
    begin
      int budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL drain pending=%0d want=0", exp_q.size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t want=finish", $time);
    $fatal(1, "timeout");
  end
endmodule
